// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: drives columns one at a time, samples active-low rows,
// debounces whole-keypad frame results and emits a stable key code plus press/release pulses.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV   = 4096,
  parameter int unsigned DEB_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [4:0] key_code,
  output logic       key_press,
  output logic       key_release,
  output logic       key_multi
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_FRAMES);
  localparam logic [4:0]    CODE_MULTI = 5'd31;

  logic [3:0]    row_meta;
  logic [3:0]    row_sync;
  logic [PW-1:0] presc;
  logic [1:0]    col_idx;
  logic [1:0]    acc_hits;
  logic [4:0]    acc_code;
  logic [4:0]    cand;
  logic [DW-1:0] deb_cnt;

  logic          sample;
  logic          frame_end;
  logic [1:0]    hits;
  logic [4:0]    code;
  logic [4:0]    result;
  logic [4:0]    cand_n;
  logic [DW-1:0] deb_cnt_n;
  logic          commit;
  logic [1:0]    col_idx_n;

  // Merge the current column sample into the frame accumulator; hits saturates at 2 (= many).
  always_comb begin
    sample    = (presc == PRESC_LAST);
    frame_end = sample && (col_idx == 2'd3);
    col_idx_n = col_idx + 2'd1;
    hits      = acc_hits;
    code      = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (hits == 2'd0) code = 5'({2'(r), col_idx}) + 5'd1;
        if (hits != 2'd2) hits = hits + 2'd1;
      end
    end
    case (hits)
      2'd0:    result = 5'd0;
      2'd1:    result = code;
      default: result = CODE_MULTI;
    endcase
  end

  // Debounce bookkeeping and commit decision, all taken at the frame-end sample.
  always_comb begin
    cand_n    = cand;
    deb_cnt_n = deb_cnt;
    if (frame_end) begin
      if (result == cand) begin
        if (deb_cnt != DEB_MAX) deb_cnt_n = deb_cnt + DW'(1);
      end else begin
        cand_n    = result;
        deb_cnt_n = DW'(1);
      end
    end
    commit = frame_end && (deb_cnt_n == DEB_MAX) && (cand_n != CODE_MULTI) && (cand_n != key_code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta    <= 4'hF;
      row_sync    <= 4'hF;
      presc       <= '0;
      col_idx     <= 2'd0;
      col         <= 4'b1110;
      acc_hits    <= 2'd0;
      acc_code    <= 5'd0;
      cand        <= 5'd0;
      deb_cnt     <= '0;
      key_code    <= 5'd0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_multi   <= 1'b0;
    end else begin
      row_meta    <= row;
      row_sync    <= row_meta;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      cand        <= cand_n;
      deb_cnt     <= deb_cnt_n;
      if (sample) begin
        presc   <= '0;
        col_idx <= col_idx_n;
        col     <= ~(4'b0001 << col_idx_n);
        if (frame_end) begin
          acc_hits  <= 2'd0;
          acc_code  <= 5'd0;
          key_multi <= (result == CODE_MULTI);
        end else begin
          acc_hits <= hits;
          acc_code <= code;
        end
      end else begin
        presc <= presc + PW'(1);
      end
      if (commit) begin
        key_code    <= cand_n;
        key_press   <= (cand_n != 5'd0);
        key_release <= (cand_n == 5'd0);
      end
    end
  end

endmodule
